// File: rtl/sparse_weight_sequencer_if.sv
// sparse_weight_sequencer_if: one compressed weight block per valid/ready handshake
interface sparse_weight_sequencer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ARRAY_SIZE = 4,
    parameter int MASK_WIDTH = 4,
    parameter int NNZ_MAX    = 8,
    parameter int CNT_WIDTH  = 4
);
    logic                                      in_valid;
    logic                                      in_ready;
    logic [ARRAY_SIZE*NNZ_MAX*DATA_WIDTH-1:0]  in_weight;
    logic [ARRAY_SIZE*NNZ_MAX*MASK_WIDTH-1:0]  in_mask;
    logic [ARRAY_SIZE*CNT_WIDTH-1:0]           in_count;
    logic                                      in_last;
    modport master (output in_valid, in_weight, in_mask, in_count, in_last, input in_ready);
    modport slave  (input in_valid, in_weight, in_mask, in_count, in_last, output in_ready);
endinterface

// File: rtl/sparse_weight_sequencer.sv
// sparse_weight_sequencer: double-buffered replay of sparse weight blocks into the PE array
module sparse_weight_sequencer #(
    parameter int DATA_WIDTH   = 8,
    parameter int ARRAY_SIZE   = 4,
    parameter int MASK_WIDTH   = 4,
    parameter int NNZ_MAX      = 8,
    parameter int CNT_WIDTH    = 4,
    parameter int GAP_CYCLES   = 3,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                             Clk,
    input  logic                             rst,
    sparse_weight_sequencer_if.slave         blk,
    output logic [ARRAY_SIZE*DATA_WIDTH-1:0] out_weight,
    output logic [ARRAY_SIZE*MASK_WIDTH-1:0] out_mask,
    output logic                             Block_control,
    output logic                             Control,
    output logic                             ResultCapture,
    output logic                             busy,
    output logic                             err_count
);
    localparam int WW = ARRAY_SIZE*NNZ_MAX*DATA_WIDTH;
    localparam int MW = ARRAY_SIZE*NNZ_MAX*MASK_WIDTH;
    localparam int CW = ARRAY_SIZE*CNT_WIDTH;
    localparam int SW = $clog2(NNZ_MAX);
    typedef enum logic [2:0] {IDLE, STREAM, GAP, DRAIN, CAPTURE} state_t;
    state_t                          state;
    logic [CNT_WIDTH-1:0]            cnt;
    logic [WW-1:0]                   act_w, sh_w;
    logic [MW-1:0]                   act_m, sh_m;
    logic [CW-1:0]                   act_c, sh_c, clamp_c;
    logic                            act_last, sh_last, sh_full, tile_open;
    logic                            xfer, accept, gap_end, last_cyc;
    logic [ARRAY_SIZE-1:0]           row_over;
    logic [ARRAY_SIZE*DATA_WIDTH-1:0] slot_w;
    logic [ARRAY_SIZE*MASK_WIDTH-1:0] slot_m;
    for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_row
        logic [CNT_WIDTH-1:0] c;
        logic                 live;
        assign c = blk.in_count[r*CNT_WIDTH +: CNT_WIDTH];
        assign row_over[r] = c > CNT_WIDTH'(NNZ_MAX);
        assign clamp_c[r*CNT_WIDTH +: CNT_WIDTH] = row_over[r] ? CNT_WIDTH'(NNZ_MAX) : c;
        assign live = cnt < act_c[r*CNT_WIDTH +: CNT_WIDTH];
        assign slot_w[r*DATA_WIDTH +: DATA_WIDTH] =
            live ? act_w[(r*NNZ_MAX + 32'(cnt[SW-1:0]))*DATA_WIDTH +: DATA_WIDTH] : '0;
        assign slot_m[r*MASK_WIDTH +: MASK_WIDTH] =
            live ? act_m[(r*NNZ_MAX + 32'(cnt[SW-1:0]))*MASK_WIDTH +: MASK_WIDTH] : '0;
    end
    assign gap_end  = state == GAP && cnt == CNT_WIDTH'(GAP_CYCLES-1);
    assign last_cyc = gap_end || (state == STREAM && cnt == CNT_WIDTH'(NNZ_MAX-1))
                    || (state == DRAIN && cnt == CNT_WIDTH'(DRAIN_CYCLES-1));
    // A tile's last block never pulls the next one in; it must drain and capture first.
    assign xfer     = sh_full && (state == IDLE || (gap_end && !act_last));
    assign blk.in_ready = !sh_full || xfer;
    assign accept   = blk.in_valid && blk.in_ready;
    assign busy     = state != IDLE || sh_full;
    always_ff @(posedge Clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            sh_full       <= 1'b0;
            act_last      <= 1'b0;
            tile_open     <= 1'b0;
            err_count     <= 1'b0;
            out_weight    <= '0;
            out_mask      <= '0;
            Block_control <= 1'b0;
            Control       <= 1'b0;
            ResultCapture <= 1'b1;
        end else begin
            out_weight    <= state == STREAM ? slot_w : '0;
            out_mask      <= state == STREAM ? slot_m : '0;
            Block_control <= state == STREAM;
            Control       <= state != CAPTURE && (state != IDLE || tile_open);
            ResultCapture <= state != CAPTURE;
            cnt           <= (state == IDLE || state == CAPTURE || last_cyc) ? '0 : cnt + CNT_WIDTH'(1);
            sh_full       <= accept || (sh_full && !xfer);
            if (accept) begin
                sh_w      <= blk.in_weight;
                sh_m      <= blk.in_mask;
                sh_c      <= clamp_c;
                sh_last   <= blk.in_last;
                err_count <= err_count | (|row_over);
            end
            if (xfer) begin
                act_w    <= sh_w;
                act_m    <= sh_m;
                act_c    <= sh_c;
                act_last <= sh_last;
            end
            tile_open <= state == CAPTURE ? 1'b0 : xfer ? 1'b1 : tile_open;
            case (state)
                IDLE:    state <= xfer ? STREAM : IDLE;
                STREAM:  state <= last_cyc ? GAP : STREAM;
                GAP:     state <= !last_cyc ? GAP : act_last ? DRAIN : xfer ? STREAM : IDLE;
                DRAIN:   state <= last_cyc ? CAPTURE : DRAIN;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sparse_weight_sequencer.sv
// tb_sparse_weight_sequencer: randomized blocks checked slot-by-slot against an array model
`timescale 1ns/1ps
module tb_sparse_weight_sequencer;
    localparam int DW = 8, AS = 4, MW = 4, NZ = 8, CW = 4;
    logic Clk = 1'b0;
    logic rst = 1'b1;
    logic [AS*DW-1:0] out_weight;
    logic [AS*MW-1:0] out_mask;
    logic Block_control, Control, ResultCapture, busy, err_count;
    int checks = 0, errors = 0;
    logic [DW-1:0] mw [4][AS][NZ];
    logic [MW-1:0] mm [4][AS][NZ];
    int            mc [4][AS];
    logic          ml [4];
    logic          exp_err = 1'b0;

    sparse_weight_sequencer_if bus ();
    sparse_weight_sequencer dut (
        .Clk(Clk), .rst(rst), .blk(bus.slave),
        .out_weight(out_weight), .out_mask(out_mask),
        .Block_control(Block_control), .Control(Control), .ResultCapture(ResultCapture),
        .busy(busy), .err_count(err_count)
    );

    always #5 Clk = ~Clk;

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    task automatic cyc();
        @(negedge Clk);
    endtask

    function automatic int eff(input int b, input int r);
        return mc[b][r] > NZ ? NZ : mc[b][r];
    endfunction

    function automatic logic [AS*DW-1:0] exp_w(input int b, input int k);
        exp_w = '0;
        for (int r = 0; r < AS; r++) if (k < eff(b, r)) exp_w[r*DW +: DW] = mw[b][r][k];
    endfunction

    function automatic logic [AS*MW-1:0] exp_m(input int b, input int k);
        exp_m = '0;
        for (int r = 0; r < AS; r++) if (k < eff(b, r)) exp_m[r*MW +: MW] = mm[b][r][k];
    endfunction

    task automatic gen(input int b, input logic last);
        for (int r = 0; r < AS; r++) begin
            mc[b][r] = $urandom_range(0, NZ);
            for (int k = 0; k < NZ; k++) begin
                mw[b][r][k] = DW'($urandom_range(1, 255));
                mm[b][r][k] = MW'($urandom_range(0, 15));
            end
        end
        ml[b] = last;
    endtask

    task automatic offer(input int b);
        int n = 0;
        for (int r = 0; r < AS; r++) begin
            bus.in_count[r*CW +: CW] = CW'(mc[b][r]);
            for (int k = 0; k < NZ; k++) begin
                bus.in_weight[(r*NZ+k)*DW +: DW] = mw[b][r][k];
                bus.in_mask[(r*NZ+k)*MW +: MW]   = mm[b][r][k];
            end
        end
        bus.in_last  = ml[b];
        bus.in_valid = 1'b1;
        while (bus.in_ready !== 1'b1 && n < 60) begin cyc(); n++; end
        checks++;
        if (n == 60) begin
            errors++;
            $display("FAIL offer%0d in_ready got %b want 1 within 60 cycles", b, bus.in_ready);
        end
        @(posedge Clk);
        cyc();
        bus.in_valid = 1'b0;
        for (int r = 0; r < AS; r++) if (mc[b][r] > NZ) exp_err = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        exp_err = 1'b0;
        checks++;
        if (out_weight !== '0 || out_mask !== '0 || Block_control !== 1'b0 || Control !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got w=%h m=%h bc=%b ctl=%b want 0 0 0 0", out_weight, out_mask, Block_control, Control);
        end
        checks++;
        if (ResultCapture !== 1'b1 || err_count !== 1'b0 || busy !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_status got rc=%b err=%b busy=%b rdy=%b want 1 0 0 1", ResultCapture, err_count, busy, bus.in_ready);
        end
        rst = 1'b0;
        repeat (2) cyc();
        checks++;
        if (Control !== 1'b0 || ResultCapture !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset got ctl=%b rc=%b busy=%b want 0 1 0", Control, ResultCapture, busy);
        end
    endtask

    // mode 0: full rows, w=1, masks 0..7; 1: counts {3,0,8,5}; 2: row2 count 12; 3: random counts 0..15
    task automatic test_last_block(input int mode);
        gen(0, 1'b1);
        for (int r = 0; r < AS; r++) begin
            if (mode == 0) begin
                mc[0][r] = NZ;
                for (int k = 0; k < NZ; k++) begin mw[0][r][k] = 8'd1; mm[0][r][k] = MW'(k); end
            end
            if (mode == 3) mc[0][r] = $urandom_range(0, 15);
        end
        if (mode == 1) begin mc[0][0] = 3; mc[0][1] = 0; mc[0][2] = 8; mc[0][3] = 5; end
        if (mode == 2) mc[0][2] = 12;
        offer(0);
        checks++;
        if (busy !== 1'b1 || Block_control !== 1'b0) begin
            errors++;
            $display("FAIL m%0d accept_status got busy=%b bc=%b want 1 0", mode, busy, Block_control);
        end
        repeat (2) cyc();
        for (int k = 0; k < NZ; k++) begin
            checks++;
            if (Block_control !== 1'b1 || Control !== 1'b1) begin
                errors++;
                $display("FAIL m%0d slot%0d ctrl got bc=%b ctl=%b want 1 1", mode, k, Block_control, Control);
            end
            checks++;
            if (out_weight !== exp_w(0, k) || out_mask !== exp_m(0, k)) begin
                errors++;
                $display("FAIL m%0d slot%0d data got w=%h m=%h want w=%h m=%h", mode, k, out_weight, out_mask, exp_w(0, k), exp_m(0, k));
            end
            cyc();
        end
        for (int g = 0; g < 3 + 2; g++) begin
            checks++;
            if (Block_control !== 1'b0 || Control !== 1'b1 || ResultCapture !== 1'b1 || out_weight !== '0 || out_mask !== '0) begin
                errors++;
                $display("FAIL m%0d gap_drain%0d got bc=%b ctl=%b rc=%b w=%h m=%h want 0 1 1 0 0", mode, g, Block_control, Control, ResultCapture, out_weight, out_mask);
            end
            cyc();
        end
        checks++;
        if (Control !== 1'b0 || ResultCapture !== 1'b0) begin
            errors++;
            $display("FAIL m%0d capture got ctl=%b rc=%b want 0 0", mode, Control, ResultCapture);
        end
        cyc();
        checks++;
        if (Control !== 1'b0 || ResultCapture !== 1'b1 || busy !== 1'b0 || err_count !== exp_err) begin
            errors++;
            $display("FAIL m%0d after_capture got ctl=%b rc=%b busy=%b err=%b want 0 1 0 %b", mode, Control, ResultCapture, busy, err_count, exp_err);
        end
    endtask

    task automatic test_back_to_back();
        for (int b = 0; b < 3; b++) gen(b, b == 2);
        fork
            begin
                for (int b = 0; b < 3; b++) offer(b);
            end
            begin
                int n = 0;
                while (Block_control !== 1'b1 && n < 20) begin cyc(); n++; end
                checks++;
                if (n == 20) begin errors++; $display("FAIL b2b start got bc=%b want 1 within 20 cycles", Block_control); end
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < NZ; k++) begin
                        checks++;
                        if (Block_control !== 1'b1 || out_weight !== exp_w(b, k) || out_mask !== exp_m(b, k)) begin
                            errors++;
                            $display("FAIL b2b blk%0d slot%0d got bc=%b w=%h m=%h want 1 w=%h m=%h", b, k, Block_control, out_weight, out_mask, exp_w(b, k), exp_m(b, k));
                        end
                        checks++;
                        if (bus.in_ready !== (b == 2)) begin
                            errors++;
                            $display("FAIL b2b blk%0d slot%0d in_ready got %b want %b", b, k, bus.in_ready, b == 2);
                        end
                        cyc();
                    end
                    for (int g = 0; g < 3; g++) begin
                        checks++;
                        if (Block_control !== 1'b0 || Control !== 1'b1) begin
                            errors++;
                            $display("FAIL b2b blk%0d gap%0d got bc=%b ctl=%b want 0 1", b, g, Block_control, Control);
                        end
                        if (g == 1 && b < 2) begin
                            checks++;
                            if (bus.in_ready !== 1'b1) begin
                                errors++;
                                $display("FAIL b2b blk%0d transfer in_ready got %b want 1", b, bus.in_ready);
                            end
                        end
                        cyc();
                    end
                end
                repeat (2) cyc();
                checks++;
                if (ResultCapture !== 1'b0 || Control !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b capture got rc=%b ctl=%b want 0 0", ResultCapture, Control);
                end
                cyc();
            end
        join
        checks++;
        if (err_count !== exp_err) begin
            errors++;
            $display("FAIL b2b err_sticky got %b want %b", err_count, exp_err);
        end
    endtask

    task automatic test_idle_gap();
        int pulses = 0;
        logic want;
        gen(0, 1'b0);
        gen(1, 1'b1);
        offer(0);
        repeat (2) cyc();
        for (int i = 0; i < NZ + 3 + 20; i++) begin
            checks++;
            if (Control !== 1'b1 || ResultCapture !== 1'b1 || Block_control !== (i < NZ)) begin
                errors++;
                $display("FAIL idle_gap cyc%0d got ctl=%b rc=%b bc=%b want 1 1 %b", i, Control, ResultCapture, Block_control, i < NZ);
            end
            cyc();
        end
        offer(1);
        for (int i = 0; i < 30; i++) begin
            if (ResultCapture === 1'b0) pulses++;
            want = pulses == 0;
            checks++;
            if (Control !== want) begin
                errors++;
                $display("FAIL idle_gap tail%0d ctl got %b want %b", i, Control, want);
            end
            cyc();
        end
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL idle_gap capture_pulses got %0d want 1", pulses);
        end
    endtask

    task automatic test_reset_mid_stream();
        gen(0, 1'b1);
        offer(0);
        repeat (6) cyc();
        checks++;
        if (out_weight !== exp_w(0, 4) || Block_control !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid slot4 got w=%h bc=%b want w=%h bc=1", out_weight, Block_control, exp_w(0, 4));
        end
        rst = 1'b1;
        cyc();
        exp_err = 1'b0;
        checks++;
        if (out_weight !== '0 || out_mask !== '0 || Block_control !== 1'b0 || Control !== 1'b0 || ResultCapture !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid outputs got w=%h m=%h bc=%b ctl=%b rc=%b want 0 0 0 0 1", out_weight, out_mask, Block_control, Control, ResultCapture);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || busy !== 1'b0 || err_count !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid status got rdy=%b busy=%b err=%b want 1 0 0", bus.in_ready, busy, err_count);
        end
        rst = 1'b0;
        for (int i = 0; i < 25; i++) begin
            checks++;
            if (ResultCapture !== 1'b1 || Block_control !== 1'b0 || Control !== 1'b0) begin
                errors++;
                $display("FAIL rst_mid quiet%0d got rc=%b bc=%b ctl=%b want 1 0 0", i, ResultCapture, Block_control, Control);
            end
            cyc();
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_weight = '0;
        bus.in_mask   = '0;
        bus.in_count  = '0;
        bus.in_last   = 1'b0;
        test_reset();
        test_last_block(0);
        test_last_block(1);
        for (int i = 0; i < 4; i++) test_last_block(3);
        test_last_block(2);
        test_back_to_back();
        test_idle_gap();
        test_reset_mid_stream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
